// File: rtl/mem_req_pkg.sv
// Shared types and widths for the memory request initiator.
package mem_req_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned STAT_REQ_W = 32;
   localparam int unsigned STAT_TO_W = 16;

   localparam logic FUNC_LOAD  = 1'b0;
   localparam logic FUNC_STORE = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              func;
      logic [STRB_W-1:0] wstrb;
   } mem_req_t;

endpackage

// File: rtl/mem_req_initiator.sv
// Blocking single-outstanding bus initiator: client command -> out_req -> out_resp -> client result.
// A silent responder is cut off after TIMEOUT wait cycles; its late reply is swallowed via the stale flag.
// Optional build macro MEM_REQ_INIT_STATS_EN adds handshake and timeout counters.
module mem_req_initiator
   import mem_req_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              cmd_func,
   input  logic [STRB_W-1:0] cmd_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              out_req_valid,
   input  logic              out_req_ready,
   output logic              out_req_bits_is_aligned,
   output logic [ADDR_W-1:0] out_req_bits_addr,
   output logic [DATA_W-1:0] out_req_bits_data,
   output logic              out_req_bits_func,
   output logic [STRB_W-1:0] out_req_bits_wstrb,
   output logic              out_resp_ready,
   input  logic              out_resp_valid,
   input  logic [DATA_W-1:0] out_resp_bits_data,
   output logic              err_spurious
`ifdef MEM_REQ_INIT_STATS_EN
   ,
   output logic [STAT_REQ_W-1:0] stat_req_cnt,
   output logic [STAT_TO_W-1:0]  stat_timeout_cnt
`endif
);

   state_t            state_q, state_d;
   mem_req_t          req_q, req_d;
   logic              aligned_q, aligned_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              stale_q, stale_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic              spur_q, spur_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              req_valid_q, req_valid_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              req_hs;
   logic              timeout_hit;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      aligned_d   = aligned_q;
      cnt_d       = cnt_q;
      stale_d     = stale_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      spur_d      = spur_q;
      req_hs      = 1'b0;
      timeout_hit = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               req_d.addr  = cmd_addr;
               req_d.data  = cmd_data;
               req_d.func  = cmd_func;
               req_d.wstrb = cmd_wstrb;
               aligned_d   = (cmd_addr[1:0] == 2'b00);
               state_d     = REQ;
            end
         end
         REQ: begin
            if (out_req_ready) begin
               req_hs  = 1'b1;
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A response in the timeout cycle still wins.
            if (out_resp_valid) begin
               rsp_data_d = (req_q.func == FUNC_LOAD) ? out_resp_bits_data : '0;
               rsp_err_d  = 1'b0;
               state_d    = RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               stale_d     = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Out-of-window responses: first one after a timeout is the late reply, others are spurious.
      if (out_resp_valid && (state_q != WAIT)) begin
         if (stale_q) begin
            stale_d = 1'b0;
         end else begin
            spur_d = 1'b1;
         end
      end

      cmd_ready_d = (state_d == IDLE) && !stale_d;
      req_valid_d = (state_d == REQ);
      rsp_valid_d = (state_d == RESP);
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         req_q       <= '0;
         aligned_q   <= 1'b0;
         cnt_q       <= '0;
         stale_q     <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         spur_q      <= 1'b0;
         cmd_ready_q <= 1'b0;
         req_valid_q <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         aligned_q   <= aligned_d;
         cnt_q       <= cnt_d;
         stale_q     <= stale_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         spur_q      <= spur_d;
         cmd_ready_q <= cmd_ready_d;
         req_valid_q <= req_valid_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

`ifdef MEM_REQ_INIT_STATS_EN
   logic [STAT_REQ_W-1:0] stat_req_q;
   logic [STAT_TO_W-1:0]  stat_to_q;

   // Handshake counter wraps; timeout counter saturates.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_req_q <= '0;
         stat_to_q  <= '0;
      end else begin
         if (req_hs) begin
            stat_req_q <= stat_req_q + STAT_REQ_W'(1);
         end
         if (timeout_hit && (stat_to_q != '1)) begin
            stat_to_q <= stat_to_q + STAT_TO_W'(1);
         end
      end
   end

   assign stat_req_cnt     = stat_req_q;
   assign stat_timeout_cnt = stat_to_q;
`endif

   assign cmd_ready               = cmd_ready_q;
   assign out_req_valid           = req_valid_q;
   assign rsp_valid               = rsp_valid_q;
   assign rsp_data                = rsp_data_q;
   assign rsp_err                 = rsp_err_q;
   assign err_spurious            = spur_q;
   assign out_req_bits_is_aligned = aligned_q;
   assign out_req_bits_addr       = req_q.addr;
   assign out_req_bits_data       = req_q.data;
   assign out_req_bits_func       = req_q.func;
   assign out_req_bits_wstrb      = req_q.wstrb;
   assign out_resp_ready          = 1'b1;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Scoreboard bench for mem_req_initiator (TIMEOUT=8); set MEM_REQ_INIT_STATS_EN to cover the counters.
module tb_mem_req_initiator;
   import mem_req_pkg::*;

   localparam int unsigned TO = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_data = '0;
   logic        cmd_func = 1'b0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        out_req_valid;
   logic        out_req_ready = 1'b0;
   logic        out_req_bits_is_aligned;
   logic [31:0] out_req_bits_addr;
   logic [31:0] out_req_bits_data;
   logic        out_req_bits_func;
   logic [3:0]  out_req_bits_wstrb;
   logic        out_resp_ready;
   logic        out_resp_valid = 1'b0;
   logic [31:0] out_resp_bits_data = '0;
   logic        err_spurious;
`ifdef MEM_REQ_INIT_STATS_EN
   logic [31:0] stat_req_cnt;
   logic [15:0] stat_timeout_cnt;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   mem_req_initiator #(.TIMEOUT(TO), .CNT_W(16)) dut (
      .clock                   (clock),
      .reset                   (reset),
      .cmd_valid               (cmd_valid),
      .cmd_ready               (cmd_ready),
      .cmd_addr                (cmd_addr),
      .cmd_data                (cmd_data),
      .cmd_func                (cmd_func),
      .cmd_wstrb               (cmd_wstrb),
      .rsp_valid               (rsp_valid),
      .rsp_ready               (rsp_ready),
      .rsp_data                (rsp_data),
      .rsp_err                 (rsp_err),
      .out_req_valid           (out_req_valid),
      .out_req_ready           (out_req_ready),
      .out_req_bits_is_aligned (out_req_bits_is_aligned),
      .out_req_bits_addr       (out_req_bits_addr),
      .out_req_bits_data       (out_req_bits_data),
      .out_req_bits_func       (out_req_bits_func),
      .out_req_bits_wstrb      (out_req_bits_wstrb),
      .out_resp_ready          (out_resp_ready),
      .out_resp_valid          (out_resp_valid),
      .out_resp_bits_data      (out_resp_bits_data),
      .err_spurious            (err_spurious)
`ifdef MEM_REQ_INIT_STATS_EN
      ,
      .stat_req_cnt            (stat_req_cnt),
      .stat_timeout_cnt        (stat_timeout_cnt)
`endif
   );

   always #5 clock = ~clock;

   // Drive a command once cmd_ready is seen; returns on the negedge after acceptance.
   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic f,
                        input logic [3:0] s, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (ok) begin
         cmd_valid = 1'b1;
         cmd_addr  = a;
         cmd_data  = d;
         cmd_func  = f;
         cmd_wstrb = s;
         @(negedge clock);
         cmd_valid = 1'b0;
      end
   endtask

   // Accept the pending out_req; returns on the negedge after the handshake edge.
   task automatic req_handshake(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (out_req_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (ok) begin
         out_req_ready = 1'b1;
         @(negedge clock);
         out_req_ready = 1'b0;
      end
   endtask

   // One-cycle responder pulse.
   task automatic respond(input logic [31:0] d);
      out_resp_valid     = 1'b1;
      out_resp_bits_data = d;
      @(negedge clock);
      out_resp_valid     = 1'b0;
   endtask

   // Wait (bounded) for rsp_valid, capture result, and accept it.
   task automatic take_rsp(output logic [31:0] d, output logic e, output int waits, output bit ok);
      ok    = 1'b0;
      waits = 0;
      d     = '0;
      e     = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (rsp_valid === 1'b1) begin
            ok = 1'b1;
            d  = rsp_data;
            e  = rsp_err;
            break;
         end
         @(negedge clock);
         waits++;
      end
      if (ok) begin
         rsp_ready = 1'b1;
         @(negedge clock);
         rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [106:0] all_out;
      #2;
      all_out = {cmd_ready, rsp_valid, out_req_valid, rsp_err, err_spurious,
                 out_req_bits_is_aligned, out_req_bits_func, out_req_bits_wstrb,
                 rsp_data, out_req_bits_addr, out_req_bits_data};
      n_cmp++;
      if (all_out !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      n_cmp++;
      if (cmd_ready !== 1'b1 || out_resp_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release: cmd_ready=%b out_resp_ready=%b want 1 1", cmd_ready, out_resp_ready);
      end
   endtask

   task automatic test_load();
      logic [31:0] d;
      logic        er;
      int          w;
      bit          ok;
      exp_t        ex;
      sb_q.push_back('{data: 32'hDEAD_BEEF, err: 1'b0});
      issue(32'h8000_0010, 32'h0, FUNC_LOAD, 4'hF, ok);
      n_cmp++;
      if (!ok || out_req_valid !== 1'b1 || cmd_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL load_req_valid: ok=%b req_valid=%b cmd_ready=%b want 1 1 0", ok, out_req_valid, cmd_ready);
      end
      n_cmp++;
      if (out_req_bits_addr !== 32'h8000_0010 || out_req_bits_is_aligned !== 1'b1 ||
          out_req_bits_func !== FUNC_LOAD) begin
         n_bad++;
         $display("FAIL load_bits: addr=%h aligned=%b func=%b want 80000010 1 0",
                  out_req_bits_addr, out_req_bits_is_aligned, out_req_bits_func);
      end
      req_handshake(ok);
      respond(32'hDEAD_BEEF);
      take_rsp(d, er, w, ok);
      ex = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      n_cmp++;
      if (!ok || w != 0 || d !== ex.data || er !== ex.err) begin
         n_bad++;
         $display("FAIL load_rsp: ok=%b waits=%0d data=%h err=%b want 1 0 %h %b", ok, w, d, er, ex.data, ex.err);
      end
   endtask

   task automatic test_store();
      logic [31:0] d;
      logic        er;
      int          w;
      bit          ok;
      bit          stable;
      exp_t        ex;
      sb_q.push_back('{data: 32'h0, err: 1'b0});
      issue(32'h8000_0002, 32'h1234_5678, FUNC_STORE, 4'b1100, ok);
      n_cmp++;
      if (!ok || out_req_bits_is_aligned !== 1'b0 || out_req_bits_wstrb !== 4'b1100 ||
          out_req_bits_data !== 32'h1234_5678 || out_req_bits_func !== FUNC_STORE) begin
         n_bad++;
         $display("FAIL store_bits: ok=%b aligned=%b wstrb=%b data=%h func=%b want 1 0 1100 12345678 1",
                  ok, out_req_bits_is_aligned, out_req_bits_wstrb, out_req_bits_data, out_req_bits_func);
      end
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (out_req_valid !== 1'b1 || out_req_bits_addr !== 32'h8000_0002 ||
             out_req_bits_data !== 32'h1234_5678 || out_req_bits_wstrb !== 4'b1100) stable = 1'b0;
      end
      n_cmp++;
      if (!stable) begin
         n_bad++;
         $display("FAIL store_stall_stable: got unstable/dropped request want held for 5 cycles");
      end
      req_handshake(ok);
      respond(32'hFFFF_FFFF);
      take_rsp(d, er, w, ok);
      ex = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      n_cmp++;
      if (!ok || d !== ex.data || er !== ex.err) begin
         n_bad++;
         $display("FAIL store_rsp: ok=%b data=%h err=%b want 1 %h %b", ok, d, er, ex.data, ex.err);
      end
   endtask

   task automatic test_timeout();
      logic [31:0] d;
      logic        er;
      int          w;
      bit          ok;
      bit          held;
      exp_t        ex;
      sb_q.push_back('{data: 32'h0, err: 1'b1});
      issue(32'h8000_0020, 32'h0, FUNC_LOAD, 4'hF, ok);
      req_handshake(ok);
      take_rsp(d, er, w, ok);
      ex = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      n_cmp++;
      if (!ok || w != int'(TO) || d !== ex.data || er !== ex.err) begin
         n_bad++;
         $display("FAIL timeout_rsp: ok=%b waits=%0d data=%h err=%b want 1 %0d %h %b",
                  ok, w, d, er, TO, ex.data, ex.err);
      end
      held = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (cmd_ready !== 1'b0) held = 1'b0;
         @(negedge clock);
      end
      n_cmp++;
      if (!held) begin
         n_bad++;
         $display("FAIL timeout_stale_block: cmd_ready went high want 0 while stale");
      end
      respond(32'hCAFE_F00D);
      n_cmp++;
      if (cmd_ready !== 1'b1 || err_spurious !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_late_resp: cmd_ready=%b err_spurious=%b want 1 0", cmd_ready, err_spurious);
      end
   endtask

   task automatic test_reset_mid();
      logic [106:0] all_out;
      bit           ok;
      issue(32'h8000_0040, 32'h0, FUNC_LOAD, 4'hF, ok);
      req_handshake(ok);
      #2;
      reset = 1'b0;
      #1;
      all_out = {cmd_ready, rsp_valid, out_req_valid, rsp_err, err_spurious,
                 out_req_bits_is_aligned, out_req_bits_func, out_req_bits_wstrb,
                 rsp_data, out_req_bits_addr, out_req_bits_data};
      n_cmp++;
      if (!ok || all_out !== '0) begin
         n_bad++;
         $display("FAIL reset_mid_async: ok=%b outputs=%h want 0", ok, all_out);
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      n_cmp++;
      if (cmd_ready !== 1'b1 || out_req_valid !== 1'b0 || err_spurious !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid_release: cmd_ready=%b req_valid=%b spur=%b want 1 0 0",
                  cmd_ready, out_req_valid, err_spurious);
      end
      respond(32'h0BAD_0BAD);
      n_cmp++;
      if (err_spurious !== 1'b1 || cmd_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL spurious_set: err_spurious=%b cmd_ready=%b want 1 1", err_spurious, cmd_ready);
      end
   endtask

   task automatic test_spurious_sticky();
      logic [31:0] d;
      logic [31:0] rd;
      logic        er;
      logic        f;
      int          w;
      bit          ok;
      exp_t        ex;
      for (int i = 0; i < 3; i++) begin
         f  = (i == 1) ? FUNC_STORE : FUNC_LOAD;
         rd = $urandom;
         sb_q.push_back('{data: (f == FUNC_LOAD) ? rd : 32'h0, err: 1'b0});
         issue(32'h9000_0000 + 32'(i * 4), $urandom, f, 4'hF, ok);
         req_handshake(ok);
         for (int k = 0; k < i; k++) @(negedge clock);
         respond(rd);
         take_rsp(d, er, w, ok);
         ex = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
         n_cmp++;
         if (!ok || d !== ex.data || er !== ex.err || err_spurious !== 1'b1) begin
            n_bad++;
            $display("FAIL sticky_txn%0d: ok=%b data=%h err=%b spur=%b want 1 %h %b 1",
                     i, ok, d, er, err_spurious, ex.data, ex.err);
         end
      end
   endtask

`ifdef MEM_REQ_INIT_STATS_EN
   task automatic test_stats();
      logic [31:0] d;
      logic        er;
      int          w;
      bit          ok;
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         issue(32'hA000_0000 + 32'(i * 4), 32'h0, FUNC_LOAD, 4'hF, ok);
         req_handshake(ok);
         respond(32'(i));
         take_rsp(d, er, w, ok);
      end
      issue(32'hA000_0100, 32'h0, FUNC_LOAD, 4'hF, ok);
      req_handshake(ok);
      take_rsp(d, er, w, ok);
      n_cmp++;
      if (stat_req_cnt !== 32'd4 || stat_timeout_cnt !== 16'd1) begin
         n_bad++;
         $display("FAIL stats: req=%0d timeout=%0d want 4 1", stat_req_cnt, stat_timeout_cnt);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_load();
      test_store();
      test_timeout();
      test_reset_mid();
      test_spurious_sticky();
`ifdef MEM_REQ_INIT_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_req_initiator.md
Name: mem_req_initiator

Overview:
- Bus initiator for the simulation memory/device request–response interface. It is the master side that drives the SimDDR/SimDev-style responders.
- Accepts one command at a time from an upstream client (fetch or LSU stub) and issues it as an out_req transaction.
- Waits for out_resp, then returns the data, or a timeout error, to the client.
- Blocking: at most one transaction outstanding.

Parameters:
- TIMEOUT, 1024: WAIT cycles allowed before reporting a timeout error. Legal range is 2..65535.
- CNT_W, 16: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  client command valid
- cmd_ready  out  1  initiator can accept a command
- cmd_addr  in  32  byte address
- cmd_data  in  32  store data
- cmd_func  in  1  0=load, 1=store
- cmd_wstrb  in  4  byte strobes; ignored for loads
- rsp_valid  out  1  result valid to client
- rsp_ready  in  1  client accepts result
- rsp_data  out  32  load data (0 on store or error)
- rsp_err  out  1  1 = transaction timed out
- out_req_valid  out  1  request valid to responder
- out_req_ready  in  1  responder accepts
- out_req_bits_is_aligned  out  1  addr[1:0]==0
- out_req_bits_addr  out  32  latched address
- out_req_bits_data  out  32  latched data
- out_req_bits_func  out  1  latched func
- out_req_bits_wstrb  out  4  latched wstrb
- out_resp_ready  out  1  tied 1 (responders do not honour backpressure)
- out_resp_valid  in  1  response valid (single-cycle pulse)
- out_resp_bits_data  in  32  response data
- err_spurious  out  1  sticky flag: unexpected response seen

Behaviour:
- Reset (async, reset==0):
  - state=IDLE; stale=0; cnt=0; err_spurious=0.
  - All valid outputs 0; rsp_data=0; rsp_err=0; out_req_bits_* = 0.
  - A reset mid-transaction abandons it; any late response is then flagged as spurious.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - cmd_ready = !stale.
  - On cmd_valid&&cmd_ready, latch addr/data/func/wstrb and go to REQ. The cycle after acceptance shows out_req_valid=1.
- REQ:
  - out_req_valid=1; out_req_bits_* hold stable.
  - On out_req_ready: go to WAIT, cnt=0.
  - No timeout applies in REQ.
- WAIT:
  - cnt increments each cycle.
  - If out_resp_valid: capture data (loads) or 0 (stores); rsp_err=0; go to RESP.
  - Else if cnt==TIMEOUT-1: rsp_data=0, rsp_err=1, stale=1; go to RESP.
  - If a response and the timeout hit in the same cycle, the response wins and no error is reported.
- RESP:
  - rsp_valid=1 with data and err held.
  - On rsp_ready: go to IDLE.
  - Minimum round-trip latency: cmd accept T → REQ T+1 → WAIT T+2 (if out_req_ready at T+1) → rsp_valid the cycle after out_resp_valid.
- stale flag:
  - Set on timeout.
  - Cleared by the next out_resp_valid seen in any state. That response is discarded and does not set err_spurious.
  - cmd_ready stays low while stale==1.
- Spurious response: out_resp_valid while state!=WAIT and stale==0 sets err_spurious=1. The flag is cleared only by reset and the response data is discarded.
- cmd_ready, out_req_valid and rsp_valid are driven directly from state/regs; there are no combinational valid→ready paths.

Optional Feature:
- MEM_REQ_INIT_STATS_EN: when defined, adds two output ports:
  - stat_req_cnt [31:0]: counts completed out_req handshakes; wraps at 2^32.
  - stat_timeout_cnt [15:0]: counts timeouts; saturates at 0xFFFF.
  - Both reset to 0.
- When undefined, these ports and their counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package mem_req_pkg holds:
  - state enum {IDLE, REQ, WAIT, RESP}
  - FUNC_LOAD=1'b0, FUNC_STORE=1'b1
  - struct mem_req_t {addr, data, func, wstrb}
- No sub-module; the timeout counter is inline. A separate counter module is not warranted.

Test Plan:
- Load addr=0x8000_0010, responder returns 0xDEADBEEF two cycles after accept → rsp_valid=1, rsp_data=0xDEADBEEF, rsp_err=0, is_aligned=1.
- Store addr=0x8000_0002, wstrb=4'b1100, data=0x1234_5678 → out_req_bits_is_aligned=0; bits stable while out_req_ready=0 for 5 cycles; rsp_data=0, rsp_err=0.
- TIMEOUT=8, responder silent → rsp_err=1 exactly 8 WAIT cycles after out_req handshake; cmd_ready=0 until a late out_resp_valid pulse arrives, then cmd_ready=1 and err_spurious stays 0.
- out_resp_valid pulse while IDLE with stale=0 → err_spurious=1 and remains set across 3 further transactions.
- reset asserted during WAIT → all outputs 0 asynchronously (before the next clock edge); after release, state=IDLE and cmd_ready=1.
- MEM_REQ_INIT_STATS_EN defined: 3 loads plus 1 timeout → stat_req_cnt=4, stat_timeout_cnt=1.
